// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle guess engine.
// Holds the per-letter feedback codes, the ASCII bounds for an acceptable
// letter, the blank character used for empty history rows and the FSM
// state encoding. No ports; imported by the engine and the letter scorer.
package wordle_pkg;

    // Per-letter feedback codes, two bits per position.
    localparam logic [1:0] FB_EMPTY  = 2'b00;
    localparam logic [1:0] FB_GRAY   = 2'b01;
    localparam logic [1:0] FB_YELLOW = 2'b10;
    localparam logic [1:0] FB_GREEN  = 2'b11;

    // Only upper-case ASCII letters are accepted into a guess.
    localparam logic [7:0] ASCII_A     = 8'h41;
    localparam logic [7:0] ASCII_Z     = 8'h5A;
    localparam logic [7:0] ASCII_BLANK = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ENTRY  = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3,
        S_COMMIT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/wordle_letter_scorer.sv
// Scoring datapath for one guess.
// green_en runs the single-cycle exact-match pass over all positions;
// yellow_en then scores one position per cycle (pos) against the secret,
// consuming secret letters through a used mask so repeated letters are
// never credited more often than they occur in the secret.
// Ports:
//   clk, rst_n          clock and asynchronous active-low reset
//   clear               synchronous wipe of all scoring state (game restart)
//   green_en            run the exact-match pass this cycle
//   yellow_en, pos      score position pos for presence this cycle
//   guess, secret       packed words, letter 0 in the MSBs
//   score               working score, position 0 in the MSBs
//   all_green           every position matched exactly
module wordle_letter_scorer
    import wordle_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int LETTER_W = 8,
    parameter int POS_W    = $clog2(WORD_LEN)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         green_en,
    input  logic                         yellow_en,
    input  logic [POS_W-1:0]             pos,
    input  logic [WORD_LEN*LETTER_W-1:0] guess,
    input  logic [WORD_LEN*LETTER_W-1:0] secret,
    output logic [2*WORD_LEN-1:0]        score,
    output logic                         all_green
);

    logic [LETTER_W-1:0] guess_let  [WORD_LEN];
    logic [LETTER_W-1:0] secret_let [WORD_LEN];
    logic [1:0]          fb         [WORD_LEN];
    logic [WORD_LEN-1:0] green_mask;
    logic [WORD_LEN-1:0] used_mask;
    logic [WORD_LEN-1:0] match_onehot;
    logic [LETTER_W-1:0] cur_letter;
    logic                cur_green;
    logic                match_found;

    // Unpack the words into letters and pack the feedback back out.
    always_comb begin
        for (int i = 0; i < WORD_LEN; i++) begin
            guess_let[i]  = guess[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
            secret_let[i] = secret[(WORD_LEN-1-i)*LETTER_W +: LETTER_W];
            score[2*(WORD_LEN-1-i) +: 2] = fb[i];
        end
    end

    assign all_green = &green_mask;

    // Lowest-index search for a secret letter that is neither an exact
    // match nor already credited to an earlier guess position.
    always_comb begin
        cur_letter   = '0;
        cur_green    = 1'b0;
        match_found  = 1'b0;
        match_onehot = '0;
        for (int i = 0; i < WORD_LEN; i++) begin
            if (POS_W'(i) == pos) begin
                cur_letter = guess_let[i];
                cur_green  = green_mask[i];
            end
        end
        for (int j = 0; j < WORD_LEN; j++) begin
            if (!match_found && !green_mask[j] && !used_mask[j] &&
                (secret_let[j] == cur_letter)) begin
                match_found     = 1'b1;
                match_onehot[j] = 1'b1;
            end
        end
    end

    // Green pass seeds the score; each yellow step resolves one position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            green_mask <= '0;
            used_mask  <= '0;
            for (int i = 0; i < WORD_LEN; i++) fb[i] <= FB_EMPTY;
        end else if (clear) begin
            green_mask <= '0;
            used_mask  <= '0;
            for (int i = 0; i < WORD_LEN; i++) fb[i] <= FB_EMPTY;
        end else if (green_en) begin
            used_mask <= '0;
            for (int i = 0; i < WORD_LEN; i++) begin
                green_mask[i] <= (guess_let[i] == secret_let[i]);
                fb[i]         <= (guess_let[i] == secret_let[i]) ? FB_GREEN : FB_EMPTY;
            end
        end else if (yellow_en && !cur_green) begin
            used_mask <= used_mask | match_onehot;
            for (int i = 0; i < WORD_LEN; i++) begin
                if (POS_W'(i) == pos) fb[i] <= match_found ? FB_YELLOW : FB_GRAY;
            end
        end
    end

endmodule

// File: rtl/wordle_guess_engine.sv
// Wordle game engine: letter entry, guess scoring, win/lose tracking and a
// readable history of committed guesses.
// Ports:
//   Clk, reset_n            clock and asynchronous active-low reset
//   new_game, secret_word   restart pulse and target word (letter 0 in MSBs)
//   letter_valid, letter_in enter one upper-case letter
//   backspace, submit       remove last letter / request scoring
//   hist_row                history row to read (1-cycle registered read)
//   ready                   letters are being accepted
//   letter_count, guess_idx letters entered / guesses committed
//   score_valid, score_out  one-cycle pulse with the committed score
//   submit_err              one-cycle pulse for a submit of a short guess
//   win, lose               sticky game result
//   hist_word, hist_score   history read data
module wordle_guess_engine
    import wordle_pkg::*;
#(
    parameter int WORD_LEN    = 5,
    parameter int MAX_GUESSES = 6,
    parameter int LETTER_W    = 8
) (
    input  logic                                            Clk,
    input  logic                                            reset_n,
    input  logic                                            new_game,
    input  logic [WORD_LEN*LETTER_W-1:0]                    secret_word,
    input  logic                                            letter_valid,
    input  logic [LETTER_W-1:0]                             letter_in,
    input  logic                                            backspace,
    input  logic                                            submit,
    input  logic [((MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1)-1:0] hist_row,
    output logic                                            ready,
    output logic [$clog2(WORD_LEN+1)-1:0]                   letter_count,
    output logic [$clog2(MAX_GUESSES+1)-1:0]                guess_idx,
    output logic                                            score_valid,
    output logic [2*WORD_LEN-1:0]                           score_out,
    output logic                                            submit_err,
    output logic                                            win,
    output logic                                            lose,
    output logic [WORD_LEN*LETTER_W-1:0]                    hist_word,
    output logic [2*WORD_LEN-1:0]                           hist_score
);

    localparam int ROW_W = (MAX_GUESSES > 1) ? $clog2(MAX_GUESSES) : 1;
    localparam int CNT_W = $clog2(WORD_LEN+1);
    localparam int IDX_W = $clog2(MAX_GUESSES+1);
    localparam int POS_W = $clog2(WORD_LEN);
    localparam logic [WORD_LEN*LETTER_W-1:0] BLANK_WORD = {WORD_LEN{LETTER_W'(ASCII_BLANK)}};

    state_t                       state;
    logic [WORD_LEN*LETTER_W-1:0] secret;
    logic [LETTER_W-1:0]          guess_let [WORD_LEN];
    logic [WORD_LEN*LETTER_W-1:0] guess_vec;
    logic [POS_W-1:0]             pos;
    logic [2*WORD_LEN-1:0]        score_now;
    logic                         all_green;
    logic                         letter_ok;
    logic [WORD_LEN*LETTER_W-1:0] hist_words  [MAX_GUESSES];
    logic [2*WORD_LEN-1:0]        hist_scores [MAX_GUESSES];

    assign ready     = (state == S_ENTRY);
    assign letter_ok = (letter_in >= LETTER_W'(ASCII_A)) && (letter_in <= LETTER_W'(ASCII_Z));

    always_comb begin
        for (int i = 0; i < WORD_LEN; i++) begin
            guess_vec[(WORD_LEN-1-i)*LETTER_W +: LETTER_W] = guess_let[i];
        end
    end

    wordle_letter_scorer #(
        .WORD_LEN (WORD_LEN),
        .LETTER_W (LETTER_W),
        .POS_W    (POS_W)
    ) u_scorer (
        .clk       (Clk),
        .rst_n     (reset_n),
        .clear     (new_game),
        .green_en  (state == S_GREEN),
        .yellow_en (state == S_YELLOW),
        .pos       (pos),
        .guess     (guess_vec),
        .secret    (secret),
        .score     (score_now),
        .all_green (all_green)
    );

    // Main FSM. new_game overrides everything; in ENTRY a submit is judged
    // on the count before any same-cycle edit, and that edit is discarded.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            secret       <= '0;
            letter_count <= '0;
            guess_idx    <= '0;
            pos          <= '0;
            score_valid  <= 1'b0;
            score_out    <= '0;
            submit_err   <= 1'b0;
            win          <= 1'b0;
            lose         <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) guess_let[i] <= '0;
        end else begin
            score_valid <= 1'b0;
            submit_err  <= 1'b0;
            if (new_game) begin
                state        <= S_ENTRY;
                secret       <= secret_word;
                letter_count <= '0;
                guess_idx    <= '0;
                pos          <= '0;
                score_out    <= '0;
                win          <= 1'b0;
                lose         <= 1'b0;
            end else begin
                case (state)
                    S_ENTRY: begin
                        if (submit) begin
                            if (letter_count < CNT_W'(WORD_LEN)) submit_err <= 1'b1;
                            else                                 state      <= S_GREEN;
                        end else if (backspace) begin
                            if (letter_count != '0) letter_count <= letter_count - CNT_W'(1);
                        end else if (letter_valid && letter_ok &&
                                     (letter_count < CNT_W'(WORD_LEN))) begin
                            for (int i = 0; i < WORD_LEN; i++) begin
                                if (CNT_W'(i) == letter_count) guess_let[i] <= letter_in;
                            end
                            letter_count <= letter_count + CNT_W'(1);
                        end
                    end
                    S_GREEN: begin
                        pos   <= '0;
                        state <= S_YELLOW;
                    end
                    S_YELLOW: begin
                        if (pos == POS_W'(WORD_LEN-1)) state <= S_COMMIT;
                        else                           pos   <= pos + POS_W'(1);
                    end
                    S_COMMIT: begin
                        score_out    <= score_now;
                        score_valid  <= 1'b1;
                        guess_idx    <= guess_idx + IDX_W'(1);
                        letter_count <= '0;
                        if (all_green) begin
                            win   <= 1'b1;
                            state <= S_DONE;
                        end else if (guess_idx == IDX_W'(MAX_GUESSES-1)) begin
                            lose  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            state <= S_ENTRY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // History storage: one row per committed guess, wiped on restart.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < MAX_GUESSES; r++) begin
                hist_words[r]  <= BLANK_WORD;
                hist_scores[r] <= '0;
            end
        end else if (new_game) begin
            for (int r = 0; r < MAX_GUESSES; r++) begin
                hist_words[r]  <= BLANK_WORD;
                hist_scores[r] <= '0;
            end
        end else if (state == S_COMMIT) begin
            for (int r = 0; r < MAX_GUESSES; r++) begin
                if (IDX_W'(r) == guess_idx) begin
                    hist_words[r]  <= guess_vec;
                    hist_scores[r] <= score_now;
                end
            end
        end
    end

    // Registered history read; rows not yet committed read back as blank.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_word  <= BLANK_WORD;
            hist_score <= '0;
        end else begin
            hist_word  <= BLANK_WORD;
            hist_score <= '0;
            for (int r = 0; r < MAX_GUESSES; r++) begin
                if ((ROW_W'(r) == hist_row) && (IDX_W'(r) < guess_idx)) begin
                    hist_word  <= hist_words[r];
                    hist_score <= hist_scores[r];
                end
            end
        end
    end

endmodule

// File: tb/tb_wordle_guess_engine.sv
// Self-checking bench for wordle_guess_engine (default parameters).
// Submits push the expected event (score or rejection) and its due cycle
// into a queue; a monitor on the falling clock edge pops and compares
// whenever the engine raises score_valid or submit_err.
module tb_wordle_guess_engine;

    localparam int W = 5;

    logic        Clk = 1'b0;
    logic        reset_n;
    logic        new_game;
    logic [39:0] secret_word;
    logic        letter_valid;
    logic [7:0]  letter_in;
    logic        backspace;
    logic        submit;
    logic [2:0]  hist_row;
    logic        ready;
    logic [2:0]  letter_count;
    logic [2:0]  guess_idx;
    logic        score_valid;
    logic [9:0]  score_out;
    logic        submit_err;
    logic        win;
    logic        lose;
    logic [39:0] hist_word;
    logic [9:0]  hist_score;

    wordle_guess_engine dut (
        .Clk          (Clk),
        .reset_n      (reset_n),
        .new_game     (new_game),
        .secret_word  (secret_word),
        .letter_valid (letter_valid),
        .letter_in    (letter_in),
        .backspace    (backspace),
        .submit       (submit),
        .hist_row     (hist_row),
        .ready        (ready),
        .letter_count (letter_count),
        .guess_idx    (guess_idx),
        .score_valid  (score_valid),
        .score_out    (score_out),
        .submit_err   (submit_err),
        .win          (win),
        .lose         (lose),
        .hist_word    (hist_word),
        .hist_score   (hist_score)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [9:0] score;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every score or rejection pulse must match the oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (score_valid === 1'b1 || submit_err === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_event: got score_valid=%0b submit_err=%0b, required no event",
                         score_valid, submit_err);
            end else begin
                e = sb.pop_front();
                check_output(e.is_err ? "err_event" : "score_event",
                             {62'b0, score_valid, submit_err}, e.is_err ? 64'h1 : 64'h2);
                if (!e.is_err) check_output("score_out", score_out, e.score);
                check_output("event_cycle", cyc, e.due);
            end
        end
    end

    function automatic logic [39:0] word40(input string w);
        logic [39:0] v;
        v = {5{8'h20}};
        for (int i = 0; i < 5 && i < w.len(); i++) v[(4-i)*8 +: 8] = w[i];
        return v;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_stimulus(input bit lv, input logic [7:0] li, input bit bs, input bit sub);
        letter_valid = lv;
        letter_in    = li;
        backspace    = bs;
        submit       = sub;
        tick();
        letter_valid = 1'b0;
        letter_in    = 8'h00;
        backspace    = 1'b0;
        submit       = 1'b0;
    endtask

    task automatic type_word(input string w);
        for (int i = 0; i < w.len(); i++) apply_stimulus(1'b1, w[i], 1'b0, 1'b0);
    endtask

    task automatic start_game(input string w);
        secret_word = word40(w);
        new_game    = 1'b1;
        tick();
        new_game    = 1'b0;
    endtask

    task automatic submit_scored(input logic [9:0] s);
        exp_t e;
        e.is_err = 1'b0;
        e.score  = s;
        e.due    = cyc + W + 3;
        sb.push_back(e);
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic push_reject();
        exp_t e;
        e.is_err = 1'b1;
        e.score  = '0;
        e.due    = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check_output("ready_return", ready, 1);
    endtask

    task automatic guess_word(input string w, input logic [9:0] s);
        type_word(w);
        submit_scored(s);
        wait_ready();
    endtask

    task automatic read_hist(input int row, input string w, input logic [9:0] s);
        hist_row = row[2:0];
        tick();
        check_output("hist_word", hist_word, word40(w));
        check_output("hist_score", hist_score, s);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_ready", ready, 0);
        check_output("rst_count", letter_count, 0);
        check_output("rst_guess_idx", guess_idx, 0);
        check_output("rst_score_valid", score_valid, 0);
        check_output("rst_score_out", score_out, 0);
        check_output("rst_submit_err", submit_err, 0);
        check_output("rst_win", win, 0);
        check_output("rst_lose", lose, 0);
        check_output("rst_hist_word", hist_word, word40(""));
        check_output("rst_hist_score", hist_score, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset_n      = 1'b0;
        new_game     = 1'b0;
        secret_word  = '0;
        letter_valid = 1'b0;
        letter_in    = 8'h00;
        backspace    = 1'b0;
        submit       = 1'b0;
        hist_row     = 3'd0;
        #12;
        check_reset_outputs();
        tick();
        reset_n = 1'b1;
        tick();
        check_output("idle_ready", ready, 0);
        apply_stimulus(1'b1, "C", 1'b0, 1'b0);
        check_output("idle_ignores_letter", letter_count, 0);

        // Entry editing and rejected submits.
        start_game("CRANE");
        check_output("entry_ready", ready, 1);
        check_output("entry_count", letter_count, 0);
        type_word("QWERTYU");
        check_output("count_saturates", letter_count, 5);
        repeat (6) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);
        check_output("count_backspaced", letter_count, 0);
        apply_stimulus(1'b1, 8'h61, 1'b0, 1'b0);
        apply_stimulus(1'b1, 8'h5B, 1'b0, 1'b0);
        check_output("non_upper_ignored", letter_count, 0);
        type_word("ABC");
        check_output("count_three", letter_count, 3);
        push_reject();
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        check_output("reject_keeps_count", letter_count, 3);
        check_output("reject_keeps_ready", ready, 1);
        apply_stimulus(1'b1, "D", 1'b1, 1'b0);
        check_output("backspace_wins", letter_count, 2);
        type_word("DE");
        push_reject();
        apply_stimulus(1'b1, "F", 1'b0, 1'b1);
        check_output("submit_drops_edit", letter_count, 4);
        repeat (4) apply_stimulus(1'b0, 8'h00, 1'b1, 1'b0);

        // Exact hit wins immediately.
        type_word("CRANE");
        submit_scored(10'h3FF);
        repeat (8) tick();
        check_output("win_flag", win, 1);
        check_output("win_lose_flag", lose, 0);
        check_output("done_ready", ready, 0);
        check_output("win_guess_idx", guess_idx, 1);
        apply_stimulus(1'b1, "A", 1'b0, 1'b0);
        check_output("done_ignores_letter", letter_count, 0);
        read_hist(0, "CRANE", 10'h3FF);
        read_hist(1, "", 10'h000);

        // Repeated-letter scoring.
        start_game("APPLE");
        check_output("restart_win", win, 0);
        check_output("restart_score_out", score_out, 0);
        guess_word("PAPER", 10'h2B9);
        check_output("paper_guess_idx", guess_idx, 1);
        start_game("CRANE");
        guess_word("EERIE", 10'h167);

        // Six misses lose the game.
        start_game("CRANE");
        guess_word("BBBBB", 10'h155);
        guess_word("NACRE", 10'h2AB);
        guess_word("CRANK", 10'h3FD);
        guess_word("AAAAA", 10'h175);
        guess_word("EERIE", 10'h167);
        type_word("PAPER");
        submit_scored(10'h19A);
        repeat (9) tick();
        check_output("lose_flag", lose, 1);
        check_output("lose_win_flag", win, 0);
        check_output("lose_guess_idx", guess_idx, 6);
        check_output("lose_ready", ready, 0);
        apply_stimulus(1'b1, "Q", 1'b0, 1'b0);
        check_output("lose_ignores_letter", letter_count, 0);
        check_output("score_out_holds", score_out, 10'h19A);
        read_hist(5, "PAPER", 10'h19A);
        read_hist(2, "CRANK", 10'h3FD);

        // Reset asserted in the middle of the yellow pass.
        start_game("CRANE");
        type_word("BBBBB");
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        tick();
        check_output("scoring_ready", ready, 0);
        check_output("scoring_count", letter_count, 5);
        reset_n = 1'b0;
        #1;
        check_reset_outputs();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        check_output("post_reset_idle", ready, 0);

        // new_game in the middle of the yellow pass aborts the score.
        start_game("CRANE");
        type_word("BBBBB");
        apply_stimulus(1'b0, 8'h00, 1'b0, 1'b1);
        tick();
        tick();
        start_game("APPLE");
        check_output("abort_ready", ready, 1);
        check_output("abort_count", letter_count, 0);
        check_output("abort_guess_idx", guess_idx, 0);
        repeat (10) tick();
        type_word("APPLE");
        submit_scored(10'h3FF);
        repeat (9) tick();
        check_output("abort_then_win", win, 1);

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            tick();
            n++;
        end
        check_output("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wordle_guess_engine.md
WORDLE_GUESS_ENGINE -- requirements
Module: wordle_guess_engine

Interface
REQ-001 Parameter WORD_LEN, default 5, gives the number of letters per guess (2..8).
REQ-002 Parameter MAX_GUESSES, default 6, gives the number of guesses per game (1..15).
REQ-003 Parameter LETTER_W, default 8, gives the width of one ASCII letter code.
REQ-004 Port Clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset_n, input, 1 bit, is the asynchronous, active-low reset.
REQ-006 Port new_game, input, 1 bit, is a start pulse; it loads secret_word.
REQ-007 Port secret_word, input, WORD_LEN*LETTER_W bits, holds the target word with letter 0 in the MSBs.
REQ-008 Port letter_valid, input, 1 bit, enters letter_in into the current guess.
REQ-009 Port letter_in, input, LETTER_W bits, is the ASCII letter to enter.
REQ-010 Port backspace, input, 1 bit, removes the last entered letter.
REQ-011 Port submit, input, 1 bit, requests scoring of the current guess.
REQ-012 Port hist_row, input, clog2(MAX_GUESSES) bits, selects the history row to read.
REQ-013 Port ready, output, 1 bit, is high while the block accepts letters.
REQ-014 Port letter_count, output, clog2(WORD_LEN+1) bits, gives the number of letters entered.
REQ-015 Port guess_idx, output, clog2(MAX_GUESSES+1) bits, gives the number of committed guesses.
REQ-016 Port score_valid, output, 1 bit, is a one-cycle pulse marking a committed score.
REQ-017 Port score_out, output, 2*WORD_LEN bits, gives per-letter feedback with position 0 in the MSBs.
REQ-018 Port submit_err, output, 1 bit, is a one-cycle pulse marking a rejected submit.
REQ-019 Ports win and lose, outputs, 1 bit each, are sticky game-result flags.
REQ-020 Ports hist_word (WORD_LEN*LETTER_W bits) and hist_score (2*WORD_LEN bits), outputs, give the history read data.

Function
REQ-021 Feedback codes SHALL be 00 empty, 01 gray, 10 yellow, 11 green.
REQ-022 The FSM SHALL have the states IDLE, ENTRY, GREEN, YELLOW, COMMIT and DONE.
REQ-023 IDLE and DONE SHALL move to ENTRY on new_game, which latches secret_word, clears history, and sets letter_count and guess_idx to 0.
REQ-024 A new_game in any state SHALL abort the current activity, restart the game, and take priority over all other inputs.
REQ-025 In ENTRY, ready SHALL be 1; in every other state, ready SHALL be 0 and letter_valid, backspace and submit SHALL be ignored.
REQ-026 letter_valid SHALL be ignored when letter_count==WORD_LEN or letter_in is outside 0x41..0x5A.
REQ-027 backspace SHALL be ignored when letter_count==0, and SHALL win over letter_valid in the same cycle.
REQ-028 submit with letter_count<WORD_LEN SHALL pulse submit_err for one cycle and leave the state unchanged.
REQ-029 submit with a full guess SHALL move to GREEN; submit in the same cycle as letter_valid or backspace SHALL be evaluated against the pre-edit count, and the edit SHALL be dropped.
REQ-030 GREEN SHALL take 1 cycle and mark every position where guess[i]==secret[i].
REQ-031 YELLOW SHALL take exactly WORD_LEN cycles, one per position i in ascending order.
REQ-032 In YELLOW, a non-green position i SHALL become yellow when the lowest secret index j that is non-green, unused, and has secret[j]==guess[i] exists; j SHALL then be marked used.
REQ-033 In YELLOW, a non-green position i with no matching j SHALL become gray.
REQ-034 COMMIT SHALL write the guess and score to history[guess_idx], pulse score_valid with score_out, increment guess_idx, and clear letter_count.
REQ-035 score_valid SHALL occur exactly WORD_LEN+2 cycles after the submit edge.
REQ-036 After COMMIT, an all-green score SHALL set win=1 and move to DONE.
REQ-037 After COMMIT, a non-winning score with guess_idx==MAX_GUESSES SHALL set lose=1 and move to DONE.
REQ-038 After COMMIT, any other result SHALL return the FSM to ENTRY.
REQ-039 History reads SHALL be registered with 1-cycle latency.
REQ-040 A history read of a row >= guess_idx SHALL return spaces (0x20) and a 00 score.
REQ-041 score_out SHALL hold its last value until the next COMMIT or game restart.

Reset
REQ-042 While reset_n is low, all outputs SHALL be 0, the state SHALL be IDLE, hist_word SHALL be spaces, and the history and secret SHALL be cleared; this SHALL hold even mid-scoring.
REQ-043 Reset deassertion SHALL be released synchronously to Clk by the integrating top.

Structure
REQ-044 Package wordle_pkg SHALL hold the feedback codes, the ASCII bounds (0x41, 0x5A), the blank code 0x20 and the FSM state encoding.
REQ-045 Sub-module wordle_letter_scorer SHALL hold the GREEN/YELLOW datapath, the used mask and the score register.

Verification
REQ-046 Secret CRANE, guess CRANE -> score_out 11_11_11_11_11 at submit+7 cycles; win=1; state DONE.
REQ-047 Secret APPLE, guess PAPER -> score_out 10_10_11_10_01.
REQ-048 Secret CRANE, guess EERIE -> score_out 01_01_10_01_11 (excess E is gray).
REQ-049 Enter 7 letters -> letter_count=5; then 6 backspaces -> count=0; then 3 letters and submit -> submit_err pulse, no score_valid.
REQ-050 Six wrong guesses -> lose=1 after the 6th score_valid; guess_idx=6; further letters ignored; hist_row 5 returns the 6th guess.
REQ-051 reset_n low during YELLOW -> all outputs 0 on the same edge and state IDLE; new_game during YELLOW -> restart, and no score_valid.
